// File: rtl/ps2_mouse_device.sv
// PS/2 mouse device: streams 3-byte motion packets to the host and answers host
// command bytes, using open-drain PS2Clk/PS2Data with host inhibit and request-to-send handling.
module ps2_mouse_device #(
    parameter int unsigned CLK_DIV = 2000
) (
    input  logic       Clk,
    input  logic       Reset,
    inout  wire        PS2Clk,
    inout  wire        PS2Data,
    input  logic       BtLeft,
    input  logic       BtRight,
    input  logic       BtMiddle,
    input  logic [8:0] XIncrement,
    input  logic [8:0] YIncrement,
    input  logic       Send,
    output logic       Busy,
    output logic       Enabled,
    output logic       CmdValid,
    output logic [7:0] CmdByte,
    output logic       TxAbort
);

    localparam int unsigned CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, TX_BIT_HI, TX_BIT_LO, TX_GAP, INHIBIT_WAIT,
        RX_REQ, RX_LO, RX_HI, RX_ACK, RESP_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [23:0]      q_q, q_d;
    logic [1:0]       q_len_q, q_len_d;
    logic [9:0]       rx_sr_q, rx_sr_d;
    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             enabled_q, enabled_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [7:0]       cmd_byte_q, cmd_byte_d;
    logic             tx_abort_q, tx_abort_d;

    logic clk_s, data_s, host_rts, rx_ok, in_tx;

    // Frame bit idx of a device-to-host byte: start, D0..D7, odd parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic v;
        case (idx)
            4'd0:    v = 1'b0;
            4'd9:    v = ~^b;
            4'd10:   v = 1'b1;
            default: v = (idx <= 4'd8) ? b[3'(idx - 4'd1)] : 1'b1;
        endcase
        return v;
    endfunction

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign host_rts = clk_s & ~data_s;
    assign rx_ok    = (^rx_sr_q[8:0]) & rx_sr_q[9];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_d       = bit_q;
        q_d         = q_q;
        q_len_d     = q_len_q;
        rx_sr_d     = rx_sr_q;
        enabled_d   = enabled_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        tx_abort_d  = 1'b0;
        clk_sync_d  = {clk_sync_q[0], PS2Clk};
        data_sync_d = {data_sync_q[0], PS2Data};

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (host_rts) begin
                    state_d = RX_REQ;
                    cnt_d   = CNT_W'(1);
                end else if (Send && enabled_q) begin
                    q_d = {YIncrement[7:0], XIncrement[7:0], 2'b00, YIncrement[8],
                           XIncrement[8], 1'b1, BtMiddle, BtRight, BtLeft};
                    q_len_d = 2'd3;
                    bit_d   = 4'd0;
                    state_d = TX_BIT_HI;
                end
            end
            TX_BIT_HI: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    // Host holding the clock low at the end of a released phase is an inhibit.
                    if (!clk_s) begin
                        state_d    = INHIBIT_WAIT;
                        tx_abort_d = 1'b1;
                        q_len_d    = 2'd0;
                    end else begin
                        state_d = TX_BIT_LO;
                    end
                end
            end
            TX_BIT_LO: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 4'd10) begin
                        q_d     = {8'h00, q_q[23:8]};
                        q_len_d = q_len_q - 2'd1;
                        bit_d   = 4'd0;
                        state_d = (q_len_q > 2'd1) ? TX_GAP : IDLE;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = TX_BIT_HI;
                    end
                end
            end
            TX_GAP, RESP_GAP: begin
                if (host_rts) begin
                    state_d = RX_REQ;
                    cnt_d   = CNT_W'(1);
                    q_len_d = 2'd0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    state_d = TX_BIT_HI;
                end
            end
            INHIBIT_WAIT: begin
                if (!clk_s) begin
                    cnt_d = '0;
                end else if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            RX_REQ: begin
                if (!host_rts) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    rx_sr_d = '0;
                    state_d = RX_LO;
                end
            end
            RX_LO: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    rx_sr_d = {data_s, rx_sr_q[9:1]};
                    state_d = RX_HI;
                end
            end
            RX_HI: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d   = 4'd0;
                        state_d = RX_ACK;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = RX_LO;
                    end
                end
            end
            RX_ACK: begin
                // bit_q 0: ack low phase (clock and data low); 1: clock high, data released.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 4'd0) begin
                        bit_d = 4'd1;
                    end else begin
                        bit_d   = 4'd0;
                        state_d = RESP_GAP;
                        q_d     = {16'h0000, 8'hFA};
                        q_len_d = 2'd1;
                        if (rx_ok) begin
                            cmd_valid_d = 1'b1;
                            cmd_byte_d  = rx_sr_q[7:0];
                            case (rx_sr_q[7:0])
                                8'hFF: begin
                                    q_d       = {8'h00, 8'hAA, 8'hFA};
                                    q_len_d   = 2'd3;
                                    enabled_d = 1'b0;
                                end
                                8'hF4: enabled_d = 1'b1;
                                8'hF5: enabled_d = 1'b0;
                                8'hF2: begin
                                    q_d     = {8'h00, 8'h00, 8'hFA};
                                    q_len_d = 2'd2;
                                end
                                default: ;
                            endcase
                        end else begin
                            q_d = {16'h0000, 8'hFE};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_tx     = (state_d == TX_BIT_HI) || (state_d == TX_BIT_LO);
        clk_oe_d  = (state_d == TX_BIT_LO) || (state_d == RX_LO) ||
                    ((state_d == RX_ACK) && (bit_d == 4'd0));
        data_oe_d = (in_tx && !frame_bit(q_d[7:0], bit_d)) ||
                    ((state_d == RX_ACK) && (bit_d == 4'd0));
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            q_q         <= '0;
            q_len_q     <= '0;
            rx_sr_q     <= '0;
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            enabled_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= 8'h00;
            tx_abort_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            q_q         <= q_d;
            q_len_q     <= q_len_d;
            rx_sr_q     <= rx_sr_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            enabled_q   <= enabled_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_byte_q  <= cmd_byte_d;
            tx_abort_q  <= tx_abort_d;
        end
    end

    // Open-drain: only ever pull low or release.
    assign PS2Clk  = clk_oe_q  ? 1'b0 : 1'bz;
    assign PS2Data = data_oe_q ? 1'b0 : 1'bz;

    assign Busy     = busy_q;
    assign Enabled  = enabled_q;
    assign CmdValid = cmd_valid_q;
    assign CmdByte  = cmd_byte_q;
    assign TxAbort  = tx_abort_q;

endmodule

// File: tb/tb_ps2_mouse_device.sv
// Bench for ps2_mouse_device: host model with pull-ups, frame monitor and byte scoreboard.
module tb_ps2_mouse_device;

    localparam int unsigned CLK_DIV = 4;

    logic       clk;
    logic       rst;
    logic       bt_left, bt_right, bt_middle, send;
    logic [8:0] x_inc, y_inc;
    logic       busy, enabled, cmd_valid, tx_abort;
    logic [7:0] cmd_byte;
    logic       host_clk_low, host_data_low;
    wire        ps2_clk, ps2_data;

    assign ps2_clk  = host_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = host_data_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_data);

    ps2_mouse_device #(.CLK_DIV(CLK_DIV)) dut (
        .Clk(clk), .Reset(rst), .PS2Clk(ps2_clk), .PS2Data(ps2_data),
        .BtLeft(bt_left), .BtRight(bt_right), .BtMiddle(bt_middle),
        .XIncrement(x_inc), .YIncrement(y_inc), .Send(send),
        .Busy(busy), .Enabled(enabled), .CmdValid(cmd_valid),
        .CmdByte(cmd_byte), .TxAbort(tx_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    bit         host_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Device-to-host frame decoder: bits taken at each PS2Clk falling edge.
    initial begin : monitor
        logic       prev;
        logic [10:0] bits;
        int         n;
        prev = 1'b1;
        n    = 0;
        bits = '0;
        forever begin
            @(negedge clk);
            if (host_mode || rst) begin
                n = 0;
            end else if (prev === 1'b1 && ps2_clk === 1'b0) begin
                bits = {ps2_data, bits[10:1]};
                n++;
                if (n == 11) begin
                    n = 0;
                    check("frame_start", bits[0], 1'b0);
                    check("frame_parity", ^bits[9:1], 1'b1);
                    check("frame_stop", bits[10], 1'b1);
                    check("frame_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) check("frame_byte", bits[8:1], exp_q.pop_front());
                end
            end
            prev = ps2_clk;
        end
    end

    task automatic wait_clk_fall(output bit ok);
        logic p;
        p  = ps2_clk;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (p === 1'b1 && ps2_clk === 1'b0) begin
                ok = 1'b1;
                break;
            end
            p = ps2_clk;
        end
    endtask

    task automatic count_falls(input int cycles, output int n);
        logic p;
        p = ps2_clk;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (p === 1'b1 && ps2_clk === 1'b0) n++;
            p = ps2_clk;
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 0);
        repeat (2 * CLK_DIV + 2) @(negedge clk);
    endtask

    task automatic pulse_send();
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    // Host-to-device byte: request-to-send, new bit at each device falling edge, then ack check.
    task automatic host_send(input logic [7:0] d, input logic par,
                             output bit seen, output logic [7:0] byt, output logic en);
        logic [9:0] bits;
        bit         ok;
        bit         all_ok;
        bits      = {1'b1, par, d};
        all_ok    = 1'b1;
        host_mode = 1'b1;
        host_data_low = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_clk_fall(ok);
            all_ok &= ok;
            host_data_low = ~bits[i];
            if (!ok) break;
        end
        check("rx_pulses", all_ok, 1'b1);
        host_data_low = 1'b0;
        wait_clk_fall(ok);
        check("ack_pulse", ok, 1'b1);
        check("ack_data_low", ps2_data, 1'b0);
        host_mode = 1'b0;
        seen = 1'b0;
        byt  = 8'h00;
        en   = enabled;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1) begin
                seen = 1'b1;
                byt  = cmd_byte;
                en   = enabled;
            end
        end
    endtask

    initial begin
        bit         seen, ok, all_ok;
        logic [7:0] byt;
        logic       en;
        int         n;

        rst = 1'b1;
        host_clk_low = 1'b0; host_data_low = 1'b0;
        send = 1'b0; bt_left = 1'b0; bt_right = 1'b0; bt_middle = 1'b0;
        x_inc = '0; y_inc = '0;

        repeat (5) @(negedge clk);
        check("rst_ps2clk", ps2_clk, 1'b1);
        check("rst_ps2data", ps2_data, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_enabled", enabled, 1'b0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_tx_abort", tx_abort, 1'b0);
        check("rst_cmd_byte", cmd_byte, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Send while streaming is disabled must be ignored.
        pulse_send();
        count_falls(200, n);
        check("disabled_send_edges", n, 0);
        check("disabled_send_busy", busy, 1'b0);

        // Host enables streaming.
        exp_q.push_back(8'hFA);
        host_send(8'hF4, 1'b0, seen, byt, en);
        check("f4_cmd_valid", seen, 1'b1);
        check("f4_cmd_byte", byt, 8'hF4);
        check("f4_enabled", en, 1'b1);
        wait_drain("f4_resp_drain");
        check("f4_busy_after", busy, 1'b0);

        // Motion packet.
        bt_left = 1'b1; x_inc = 9'h005; y_inc = 9'h1FD;
        exp_q.push_back(8'h29); exp_q.push_back(8'h05); exp_q.push_back(8'hFD);
        pulse_send();
        check("pkt_busy", busy, 1'b1);
        wait_drain("pkt_drain");
        check("pkt_busy_after", busy, 1'b0);

        // Host inhibit during bit 3 of byte1.
        bt_left = 1'b0; bt_right = 1'b1; bt_middle = 1'b1;
        x_inc = 9'h1F0; y_inc = 9'h010;
        exp_q.push_back(8'h1E);
        pulse_send();
        all_ok = 1'b1;
        for (int i = 0; i < 14; i++) begin
            wait_clk_fall(ok);
            all_ok &= ok;
            if (!ok) break;
        end
        check("abort_lead_edges", all_ok, 1'b1);
        for (int i = 0; i < 50 && ps2_clk !== 1'b1; i++) @(negedge clk);
        check("abort_byte0_done", exp_q.size(), 0);
        host_mode = 1'b1;
        host_clk_low = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tx_abort === 1'b1) seen = 1'b1;
        end
        check("tx_abort_pulse", seen, 1'b1);
        check("abort_data_released", ps2_data, 1'b1);
        repeat (20) @(negedge clk);
        check("abort_busy_held", busy, 1'b1);
        host_clk_low = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_wait", busy, 1'b1);
        repeat (CLK_DIV + 2) @(negedge clk);
        check("abort_busy_clear", busy, 1'b0);
        host_mode = 1'b0;
        count_falls(300, n);
        check("abort_no_byte2", n, 0);

        // Bad parity command.
        exp_q.push_back(8'hFE);
        host_send(8'hFF, 1'b0, seen, byt, en);
        check("bad_par_no_valid", seen, 1'b0);
        check("bad_par_enabled", enabled, 1'b1);
        wait_drain("bad_par_drain");

        // Reset command with good parity.
        exp_q.push_back(8'hFA); exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
        host_send(8'hFF, 1'b1, seen, byt, en);
        check("ff_cmd_valid", seen, 1'b1);
        check("ff_cmd_byte", byt, 8'hFF);
        check("ff_enabled", en, 1'b0);
        wait_drain("ff_resp_drain");
        check("ff_busy_after", busy, 1'b0);
        check("ff_cmd_byte_held", cmd_byte, 8'hFF);

        // Streaming disabled again: Send ignored.
        pulse_send();
        count_falls(200, n);
        check("redisabled_send_edges", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
